// File: rtl/cnn_pkg.sv
// Shared types and widths for the CNN window-fetch datapath.
package cnn_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADDR_HALF_W = 8;
  localparam int unsigned ADDR_W      = 2 * ADDR_HALF_W;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StOut,
    StDone
  } state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ADDR_HALF_W-1:0] row,
                                                  input logic [ADDR_HALF_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/win_pos_cnt.sv
// Window origin counter: column-first walk over the map, with a final-window flag.
module win_pos_cnt
  import cnn_pkg::*;
#(
  parameter int unsigned ROW = 8,
  parameter int unsigned COL = 8,
  parameter int unsigned K   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   advance_i,
  output logic [ADDR_HALF_W-1:0] row_o,
  output logic [ADDR_HALF_W-1:0] col_o,
  output logic                   last_o
);

  localparam logic [ADDR_HALF_W-1:0] RowLast = ADDR_HALF_W'(ROW - K);
  localparam logic [ADDR_HALF_W-1:0] ColLast = ADDR_HALF_W'(COL - K);

  logic [ADDR_HALF_W-1:0] row_q, row_d;
  logic [ADDR_HALF_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == RowLast) && (col_q == ColLast);

endmodule

// File: rtl/win_fetch.sv
// Scans a ROWxCOL feature map, fetching each KxK window element-by-element from a
// one-cycle-latency memory and presenting it on a valid/ready output.
module win_fetch
  import cnn_pkg::*;
#(
  parameter int unsigned ROW = 8,
  parameter int unsigned COL = 8,
  parameter int unsigned K   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mem_we,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_en,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic [DATA_W*K*K-1:0]    win_data,
  output logic [ADDR_HALF_W-1:0]   win_row,
  output logic [ADDR_HALF_W-1:0]   win_col,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned            NElem    = K * K;
  localparam logic [15:0]            LastElem = 16'(NElem - 1);
  localparam logic [ADDR_HALF_W-1:0] KLast    = ADDR_HALF_W'(K - 1);

  state_e                   state_q, state_d;
  logic                     rd_vld_q, rd_vld_d;
  logic [ADDR_HALF_W-1:0]   i_q, i_d;
  logic [ADDR_HALF_W-1:0]   j_q, j_d;
  logic [15:0]              elem_q, elem_d;
  logic                     cap_q, cap_d;
  logic [15:0]              cap_idx_q, cap_idx_d;
  logic [DATA_W*NElem-1:0]  win_data_q, win_data_d;
  logic                     win_valid_q, win_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pos_clear, pos_adv, pos_last;
  logic                     accept;

  win_pos_cnt #(
    .ROW(ROW),
    .COL(COL),
    .K  (K)
  ) u_pos (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (pos_clear),
    .advance_i(pos_adv),
    .row_o    (win_row),
    .col_o    (win_col),
    .last_o   (pos_last)
  );

  // A write upstream suppresses the read in the same cycle; the request simply holds.
  assign rd_en   = (state_q == StFetch) && rd_vld_q && !mem_we;
  assign rd_addr = rd_vld_q ? pack_addr(win_row + i_q, win_col + j_q) : '0;
  assign accept  = win_valid_q && win_ready;

  always_comb begin
    state_d     = state_q;
    rd_vld_d    = rd_vld_q;
    i_d         = i_q;
    j_d         = j_q;
    elem_d      = elem_q;
    win_data_d  = win_data_q;
    win_valid_d = win_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pos_clear   = 1'b0;
    pos_adv     = 1'b0;

    // Read data lands one cycle after its rd_en; cap_q/cap_idx_q track that slot.
    cap_d     = rd_en;
    cap_idx_d = rd_en ? elem_q : cap_idx_q;
    for (int s = 0; s < int'(NElem); s++) begin
      if (cap_q && (cap_idx_q == 16'(s))) begin
        win_data_d[s*DATA_W +: DATA_W] = rd_data;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          busy_d    = 1'b1;
          rd_vld_d  = 1'b0;
          pos_clear = 1'b1;
        end
      end
      StFetch: begin
        if (!rd_vld_q) begin
          // First FETCH cycle arms the request at element (0,0) of the new origin.
          rd_vld_d = 1'b1;
          i_d      = '0;
          j_d      = '0;
          elem_d   = '0;
        end else if (!mem_we) begin
          if (elem_q == LastElem) begin
            rd_vld_d = 1'b0;
            state_d  = StDrain;
          end else begin
            elem_d = elem_q + 16'd1;
            if (j_q == KLast) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end
      StDrain: begin
        if (cap_q && (cap_idx_q == LastElem)) begin
          state_d     = StOut;
          win_valid_d = 1'b1;
        end
      end
      StOut: begin
        if (accept) begin
          win_valid_d = 1'b0;
          if (pos_last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StFetch;
            pos_adv = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rd_vld_q    <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      elem_q      <= '0;
      cap_q       <= 1'b0;
      cap_idx_q   <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_vld_q    <= rd_vld_d;
      i_q         <= i_d;
      j_q         <= j_d;
      elem_q      <= elem_d;
      cap_q       <= cap_d;
      cap_idx_q   <= cap_idx_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign win_data  = win_data_q;
  assign win_valid = win_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/win_fetch.md
WIN_FETCH -- requirements
Module: win_fetch

Interface
REQ-001 SHALL have parameter ROW, default 8, feature-map rows (K..255).
REQ-002 SHALL have parameter COL, default 8, feature-map columns (K..255).
REQ-003 SHALL have parameter K, default 3, square kernel/window size.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a full-map scan.
REQ-007 SHALL have port mem_we  in  1  upstream write strobe to the array memory; fetch stalls while high.
REQ-008 SHALL have port rd_addr  out  16  memory read address, {row[7:0], col[7:0]}.
REQ-009 SHALL have port rd_en  out  1  read issued this cycle.
REQ-010 SHALL have port rd_data  in  16  signed memory data, valid exactly one cycle after rd_en.
REQ-011 SHALL have port win_data  out  16*K*K  window; element (i,j) at bits [16*(i*K+j) +: 16].
REQ-012 SHALL have port win_row, win_col  out  8 each  window origin (top-left).
REQ-013 SHALL have port win_valid / win_ready  out / in  1 each  valid/ready handshake.
REQ-014 SHALL have port busy  out  1  scan in progress.
REQ-015 SHALL have port done  out  1  one-cycle pulse after the last window is accepted.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN, OUT and DONE.
REQ-017 IDLE: start=1 -> FETCH, origin (0,0); start is ignored in any other state.
REQ-018 FETCH: one read per cycle in row-major order over window elements, address {org_row+i, org_col+j}; after the K*K-th read -> DRAIN.
REQ-019 While mem_we=1, rd_en SHALL be 0, and the element counter and state SHALL hold.
REQ-020 Each rd_data SHALL be captured into its window slot one cycle after its rd_en.
REQ-021 DRAIN SHALL capture the last element, then -> OUT.
REQ-022 Without stalls, win_valid SHALL rise K*K+2 cycles after the edge that samples start.
REQ-023 OUT: win_valid=1; win_data, win_row and win_col SHALL stay stable until win_valid&&win_ready.
REQ-024 On accept, origin SHALL advance column-first up to COL-K, then wrap to column 0 and the next row, up to ROW-K; for a non-final window -> FETCH on the next cycle.
REQ-025 On acceptance of the final window (ROW-K, COL-K), the block SHALL go to DONE; done=1 for one cycle, then IDLE.
REQ-026 The block SHALL produce exactly (ROW-K+1)*(COL-K+1) windows per scan.
REQ-027 win_valid SHALL NOT depend combinationally on win_ready.
REQ-028 busy SHALL be 1 in FETCH, DRAIN, OUT and DONE, and 0 in IDLE.
REQ-029 ROW=COL=K SHALL yield a single window at (0,0).
REQ-030 Data SHALL pass through unmodified; no arithmetic is performed on samples.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, and force to 0 all of: rd_en, rd_addr, win_valid, win_data, win_row, win_col, busy, done, and counters.
REQ-032 Reset mid-scan SHALL abandon the scan; after release, no window is emitted until a new start.

Structure
REQ-033 Shared package cnn_pkg SHALL hold DATA_W=16, ADDR_HALF_W=8 and the state enumeration.
REQ-034 One sub-module, win_pos_cnt, SHALL hold the origin row/column counter with wrap and a last-window flag.

Verification
REQ-035 4x4 map with value r*4+c, K=3, win_ready=1 -> 4 windows; first is {0,1,2,4,5,6,8,9,10} at (0,0), last is {5,6,7,9,10,11,13,14,15} at (1,1); then done.
REQ-036 win_ready held 0 for 5 cycles during OUT -> win_valid stays 1, win_data is unchanged, and there is no rd_en.
REQ-037 mem_we=1 for 3 cycles mid-FETCH -> rd_en=0 for those cycles; the window still matches REQ-035 and win_valid is delayed by exactly 3 cycles.
REQ-038 rst_n pulsed low during the second window's FETCH -> all outputs are 0 immediately; after release, no activity occurs until start.
REQ-039 start pulsed during OUT -> ignored; the window count for the scan is still 4.
REQ-040 ROW=COL=K=3 -> one window at (0,0), win_valid 11 cycles after start, then done.
